// File: rtl/cpu5_ifu_if.sv
// cpu5_ifu_if: bundles the fetch unit's instruction-memory bus, the decode
// handshake and the redirect inputs coming back from cpu5_controller.
//
// Signals:
//   imem_req / imem_addr / imem_gnt   request channel to instruction memory
//   imem_rvalid / imem_rdata          in-order response channel
//   instr_valid / instr_ready         head-of-buffer handshake to decode
//   instr / instr_pc                  head instruction and its PC
//   pcsrc / jump                      redirect qualifiers for the consumed instr
//   pcbranch / pcjump                 redirect targets
//
// Modports:
//   master  the fetch unit side
//   slave   the environment side (memory plus decode/control)
interface cpu5_ifu_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;

    logic                   pcsrc;
    logic                   jump;
    logic [ADDR_WIDTH-1:0]  pcbranch;
    logic [ADDR_WIDTH-1:0]  pcjump;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               pcsrc, jump, pcbranch, pcjump
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               pcsrc, jump, pcbranch, pcjump
    );
endinterface

// File: rtl/cpu5_ifu.sv
// cpu5_ifu: instruction fetch unit for cpu5.
//
// Owns the PC, issues word-aligned fetches to instruction memory, buffers the
// in-order responses in a small FIFO and presents the head to decode through
// a valid/ready handshake. When the consumed instruction carries a taken
// branch or a jump, the buffer is flushed, every fetch still in flight is
// marked for discard and the PC is redirected to the (word-aligned) target.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   bus             cpu5_ifu_if.master (imem bus, decode handshake, redirect)
//   perf_redirects  number of redirects taken since reset
//   perf_stalls     number of cycles decode was ready but no instruction valid
//
// Optional feature: define CPU5_IFU_PERF_EN to build the two performance
// counters; otherwise both ports are tied to zero and no flops are built.
module cpu5_ifu #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int                     FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    cpu5_ifu_if.master  bus,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stalls
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  resp_pc;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          outstanding_next;
    logic [CW-1:0]          drop;
    logic [CW:0]            occupancy;

    logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];

    logic                   grant;
    logic                   resp;
    logic                   push;
    logic                   pop;
    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  target_raw;
    logic [ADDR_WIDTH-1:0]  target;

    // Buffered plus in-flight fetches are capped at FIFO_DEPTH, which is what
    // makes buffer overflow impossible without any backpressure on rvalid.
    assign occupancy    = {1'b0, outstanding} + {1'b0, count};
    assign bus.imem_req = !reset && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign bus.imem_addr = pc;

    assign grant    = bus.imem_req && bus.imem_gnt;
    // A response with nothing outstanding is a protocol error; it is ignored
    // so the counters cannot underflow.
    assign resp     = bus.imem_rvalid && (outstanding != '0);
    assign pop      = bus.instr_valid && bus.instr_ready;
    assign redirect = pop && (bus.pcsrc || bus.jump);
    assign push     = resp && (drop == '0) && !redirect;

    assign target_raw = bus.jump ? bus.pcjump : bus.pcbranch;
    assign target     = {target_raw[ADDR_WIDTH-1:2], 2'b00};

    assign outstanding_next = outstanding + CW'(grant) - CW'(resp);

    // PC, response PC, FIFO pointers and the fetch bookkeeping. On a redirect
    // every fetch still in flight after this cycle (including this cycle's
    // grant at the old PC) must be discarded, which is exactly the next value
    // of the outstanding counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (grant) begin
                pc <= pc + ADDR_WIDTH'(4);
            end
            if (redirect) begin
                pc      <= target;
                resp_pc <= target;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                drop    <= outstanding_next;
            end else begin
                if (resp && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Buffer storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = instr_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];

    rvalid_without_request : assert property (
        @(posedge clk) disable iff (reset) !(bus.imem_rvalid && (outstanding == '0))
    );

`ifdef CPU5_IFU_PERF_EN
    // Redirect and decode-starvation counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (bus.instr_ready && !bus.instr_valid) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`else
    assign perf_redirects = '0;
    assign perf_stalls    = '0;
`endif

endmodule

// File: tb/tb_cpu5_ifu.sv
// tb_cpu5_ifu: directed, scoreboard-based bench for cpu5_ifu.
//
// A small memory model answers every grant in order (one cycle later unless
// responses are held off). Every granted address is pushed to a scoreboard;
// whenever the head is valid it must match the scoreboard front, and a pop
// retires that entry. A redirect empties the scoreboard because everything
// fetched up to and including the redirect cycle must be discarded.
module tb_cpu5_ifu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ANY_PC   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] perfRedirects;
    logic [31:0] perfStalls;

    always #5 clk = ~clk;

    cpu5_ifu_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    cpu5_ifu #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .perf_redirects(perfRedirects),
        .perf_stalls   (perfStalls)
    );

    int          nVectors = 0;
    int          nMiscompares = 0;
    logic [31:0] pendQ[$];
    logic [31:0] sbQ[$];
    logic [31:0] expAddr;
    int          nRedirects = 0;
    int          nStalls = 0;
    bit          gntEn = 1'b1;
    bit          rvEn = 1'b1;
    int          cycleNo = 0;
    int          firstGrant = -1;
    int          firstValid = -1;

    // Instruction word the memory model returns for an address.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, let them settle,
    // check the head against the scoreboard and book grants and redirects.
    // pcsrc/jump are only driven when the head PC equals matchPc (or always
    // when matchPc is ANY_PC); fired reports a redirect was consumed.
    task automatic applyStimulus(input bit ready, input bit ps, input bit jp,
                                 input logic [31:0] pb, input logic [31:0] pj,
                                 input logic [31:0] matchPc, output bit fired);
        bit          applied;
        bit          grant;
        bit          pop;
        logic [31:0] tgt;
        @(negedge clk);
        applied = (matchPc === ANY_PC) || (bus.instr_valid && (bus.instr_pc === matchPc));
        bus.imem_gnt    = gntEn;
        bus.instr_ready = ready;
        bus.pcsrc       = ps && applied;
        bus.jump        = jp && applied;
        bus.pcbranch    = pb;
        bus.pcjump      = pj;
        if (rvEn && pendQ.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memData(pendQ.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
        if (bus.instr_valid === 1'b1) begin
            if (firstValid < 0) firstValid = cycleNo;
            if (sbQ.size() == 0) begin
                checkOutput("head_expected", 32'd0, 32'd1);
            end else begin
                checkOutput("instr_pc", bus.instr_pc, sbQ[0]);
                checkOutput("instr", bus.instr, memData(sbQ[0]));
            end
        end
        pop = (bus.instr_valid === 1'b1) && ready;
        if (pop && sbQ.size() > 0) void'(sbQ.pop_front());
        grant = (bus.imem_req === 1'b1) && gntEn;
        if (grant) begin
            if (firstGrant < 0) firstGrant = cycleNo;
            checkOutput("imem_addr", bus.imem_addr, expAddr);
            pendQ.push_back(bus.imem_addr);
            sbQ.push_back(expAddr);
            expAddr = expAddr + 32'd4;
        end
        fired = pop && applied && (ps || jp);
        if (fired) begin
            tgt = jp ? pj : pb;
            tgt[1:0] = 2'b00;
            sbQ.delete();
            expAddr = tgt;
            nRedirects++;
        end
        if (ready && bus.instr_valid !== 1'b1) nStalls++;
        cycleNo++;
    endtask

    task automatic runCycles(input int n, input bit ready);
        bit f;
        for (int i = 0; i < n; i++) applyStimulus(ready, 1'b0, 1'b0, '0, '0, ANY_PC, f);
    endtask

    task automatic redirectAt(input logic [31:0] pcMatch, input bit ps, input bit jp,
                              input logic [31:0] pb, input logic [31:0] pj);
        bit f;
        f = 1'b0;
        for (int i = 0; i < 40 && !f; i++) applyStimulus(1'b1, ps, jp, pb, pj, pcMatch, f);
        checkOutput("redirect_reached", {31'b0, f}, 32'd1);
    endtask

    // Assert reset at a falling edge, check outputs are at reset values at
    // once, then release shortly after a rising edge with the model cleared.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        bus.imem_rvalid = 1'b0;
        #1;
        checkOutput("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("rst_perf_redirects", perfRedirects, 32'd0);
        checkOutput("rst_perf_stalls", perfStalls, 32'd0);
        repeat (2) @(posedge clk);
        pendQ.delete();
        sbQ.delete();
        expAddr    = RESET_PC;
        nRedirects = 0;
        nStalls    = 0;
        firstGrant = -1;
        firstValid = -1;
        cycleNo    = 0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic checkPerf();
        logic [31:0] expR;
        logic [31:0] expS;
        @(posedge clk);
        #1;
`ifdef CPU5_IFU_PERF_EN
        expR = 32'(nRedirects);
        expS = 32'(nStalls);
`else
        expR = 32'd0;
        expS = 32'd0;
`endif
        checkOutput("perf_redirects", perfRedirects, expR);
        checkOutput("perf_stalls", perfStalls, expS);
    endtask

    initial begin
        bit f;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.pcsrc       = 1'b0;
        bus.jump        = 1'b0;
        bus.pcbranch    = '0;
        bus.pcjump      = '0;
        expAddr         = RESET_PC;

        // Streaming from reset with an always-granting memory.
        doReset();
        runCycles(8, 1'b1);
        checkOutput("valid_latency", 32'(firstValid - firstGrant), 32'd2);

        // Decode stalls: buffer fills, requests stop, head holds.
        // pcsrc/jump asserted without a pop must be ignored.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 32'h80, ANY_PC, f);
        checkOutput("full_imem_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("full_instr_valid", {31'b0, bus.instr_valid}, 32'd1);
        runCycles(8, 1'b1);

        // Taken branch at 0x8, then jump (priority over pcsrc) at 0x48.
        doReset();
        redirectAt(32'h8, 1'b1, 1'b0, 32'h40, 32'h0);
        redirectAt(32'h48, 1'b1, 1'b1, 32'h80, 32'h103);
        runCycles(4, 1'b1);

        // Irregular grants, delayed responses and decode stalls.
        for (int i = 0; i < 12; i++) begin
            gntEn = (i % 3 != 2);
            rvEn  = (i % 2 == 0);
            applyStimulus(i % 4 != 3, 1'b0, 1'b0, '0, '0, ANY_PC, f);
        end
        gntEn = 1'b1;
        rvEn  = 1'b1;
        redirectAt(ANY_PC, 1'b1, 1'b0, 32'h3F6, 32'h0);
        runCycles(10, 1'b1);
        checkPerf();

        // Reset mid-stream with fetches outstanding, then refetch from reset PC.
        doReset();
        runCycles(8, 1'b1);
        checkOutput("refetch_latency", 32'(firstValid - firstGrant), 32'd2);
        checkPerf();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/cpu5_ifu.md
Name: cpu5_ifu

Overview:
Instruction fetch unit for cpu5, sitting at the other end of the pcsrc/jump interface driven by cpu5_controller. It owns the PC and issues requests to instruction memory. Returned instructions are buffered and presented to the decode/control stage through a valid/ready handshake. When the consumed instruction resolves a taken branch or jump, the unit flushes its buffer, discards in-flight responses and redirects the PC to the target.

Parameters:
ADDR_WIDTH, 32, width of PC and imem address
INSTR_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC after reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on buffered plus in-flight fetches (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_WIDTH  fetch address (word aligned)
imem_gnt  input  1  request accepted this cycle when imem_req=1
imem_rvalid  input  1  response valid; responses return in order, >=1 cycle after grant
imem_rdata  input  INSTR_WIDTH  response instruction
instr_valid  output  1  buffer head valid
instr_ready  input  1  decode consumes head
instr  output  INSTR_WIDTH  head instruction (op/funct fields feed the controller)
instr_pc  output  ADDR_WIDTH  PC of head instruction
pcsrc  input  1  taken branch for the consumed instruction (from controller)
jump  input  1  jump for the consumed instruction (from controller)
pcbranch  input  ADDR_WIDTH  branch target
pcjump  input  ADDR_WIDTH  jump target
perf_redirects  output  32  redirect count (see Optional Feature)
perf_stalls  output  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset (async, active-high): pc=RESET_PC, resp_pc=RESET_PC, buffer empty, outstanding=0, drop=0. imem_req=0, instr_valid=0, perf counters 0. First imem_req in the first cycle after reset deasserts.
- imem_req = (outstanding + count) < FIFO_DEPTH; imem_addr = pc. Both hold stable until imem_gnt.
- On imem_req & imem_gnt: pc += 4 and outstanding++.
- On imem_rvalid: outstanding--.
  - If drop > 0: drop-- and the data is discarded.
  - Otherwise push {imem_rdata, resp_pc} and resp_pc += 4.
- Latency: rvalid in cycle N gives instr_valid in cycle N+1 at the earliest (registered buffer, no bypass).
- Handshake: the head pops on instr_valid & instr_ready. instr and instr_pc hold stable while instr_valid & !instr_ready. Push and pop in the same cycle are legal, including when the buffer is full.
- Overflow cannot occur by construction; an rvalid with outstanding=0 is a protocol error (assertion).
- redirect = instr_valid & instr_ready & (pcsrc | jump). pcsrc/jump are ignored when there is no pop.
  - Target: pcjump if jump, else pcbranch (jump has priority). Target bits [1:0] are forced to 0.
  - Next cycle: pc = resp_pc = target and the buffer is flushed (a same-cycle push is also discarded).
  - drop = outstanding + (imem_req & imem_gnt) - imem_rvalid. A same-cycle grant at the old PC is dropped, as is a same-cycle rvalid.
  - The redirect cycle's own request is still a legal old-PC fetch.
- Back-to-back redirects: the second overwrites pc and accumulates drop correctly; drop never underflows.

Optional Feature:
- Macro CPU5_IFU_PERF_EN.
- Defined:
  - perf_redirects increments on each redirect.
  - perf_stalls increments each cycle with instr_ready=1 and instr_valid=0.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Reset release, imem always granting, rvalid 1 cycle after grant, instr_ready=1 -> addresses 0x0,0x4,0x8..., instr_valid first high 2 cycles after first grant, instr_pc matches the address of each instruction.
- instr_ready=0 for 10 cycles -> buffer fills to 2, imem_req drops once outstanding+count=2, head instr/instr_pc stable, no instructions lost after ready returns.
- Pop at instr_pc=0x8 with pcsrc=1, pcbranch=0x40, 2 fetches in flight -> both responses discarded, next instr_pc=0x40, next imem_addr=0x40.
- Same pop with jump=1 and pcsrc=1, pcjump=0x103, pcbranch=0x80 -> redirect to 0x100.
- Assert reset mid-stream with fetches outstanding -> all outputs immediately at reset values, refetch from RESET_PC; late rvalid before the first new grant is a checked error.
- With CPU5_IFU_PERF_EN: 3 redirects and 5 starved cycles -> perf_redirects=3, perf_stalls=5; without the macro both read 0.
